// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display stages.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [2:0] DIG_DP_LO = 3'd2;
  localparam logic [2:0] DIG_DP_HI = 3'd4;
  localparam logic [2:0] DIG_LEAD  = 3'd5;

  // digits[0] = sec_ones ... digits[5] = hour_tens
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic                       blank_lead_zero;
    logic                       sep_on;
    logic [3:0]                 brightness;
  } shadow_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to active-low 7-segment decoder ({g,f,e,d,c,b,a}); values above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = 7'h40;
      4'd1: o_seg = 7'h79;
      4'd2: o_seg = 7'h24;
      4'd3: o_seg = 7'h30;
      4'd4: o_seg = 7'h19;
      4'd5: o_seg = 7'h12;
      4'd6: o_seg = 7'h02;
      4'd7: o_seg = 7'h78;
      4'd8: o_seg = 7'h00;
      4'd9: o_seg = 7'h10;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 6-digit common-anode driver with per-frame input shadowing,
// PWM brightness (phase 0 always dark), leading-zero blanking and separator dots.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_sec_ones,
  input  logic [3:0] i_sec_tens,
  input  logic [3:0] i_min_ones,
  input  logic [3:0] i_min_tens,
  input  logic [3:0] i_hour_ones,
  input  logic [3:0] i_hour_tens,
  input  logic       i_blank_lead_zero,
  input  logic       i_sep_on,
  input  logic [3:0] i_brightness,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [5:0] o_an
);

  logic [SCAN_W-1:0] r_cnt;
  logic [2:0]        r_dig;
  shadow_t           r_shadow;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [5:0]        r_an;

  shadow_t    w_inputs;
  logic       w_slot_end;
  logic       w_capture;
  logic [3:0] w_phase;
  logic [3:0] w_val;
  logic [6:0] w_glyph;
  logic       w_lead_blank;
  logic       w_an_on;
  logic       w_sep_pos;
  logic [6:0] w_seg_d;
  logic       w_dp_d;
  logic [5:0] w_an_d;

  assign w_inputs.digits          = {i_hour_tens, i_hour_ones, i_min_tens,
                                     i_min_ones, i_sec_tens, i_sec_ones};
  assign w_inputs.blank_lead_zero = i_blank_lead_zero;
  assign w_inputs.sep_on          = i_sep_on;
  assign w_inputs.brightness      = i_brightness;

  assign w_slot_end = &r_cnt;
  // Capture on the last cycle of the frame so every frame shows one coherent time.
  assign w_capture  = w_slot_end && (r_dig == DIG_LEAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_dig    <= '0;
      r_shadow <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_slot_end) begin
        r_dig <= (r_dig == DIG_LEAD) ? 3'd0 : r_dig + 3'd1;
      end
      if (w_capture) begin
        r_shadow <= w_inputs;
      end
    end
  end

  assign w_phase = r_cnt[SCAN_W-1 -: 4];
  assign w_an_on = (w_phase != 4'd0) && (w_phase <= r_shadow.brightness);

  always_comb begin
    w_val  = '0;
    w_an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_dig == 3'(i)) begin
        w_val = r_shadow.digits[i];
        if (w_an_on) w_an_d[i] = 1'b0;
      end
    end
  end

  bcd_to_seg7 u_decode (
    .i_bcd (w_val),
    .o_seg (w_glyph)
  );

  assign w_lead_blank = (r_dig == DIG_LEAD) && r_shadow.blank_lead_zero &&
                        (r_shadow.digits[NUM_DIGITS-1] == 4'd0);
  assign w_sep_pos    = (r_dig == DIG_DP_LO) || (r_dig == DIG_DP_HI);
  assign w_seg_d      = w_lead_blank ? SEG_BLANK : w_glyph;
  assign w_dp_d       = w_lead_blank ? 1'b1 : ~(w_sep_pos && r_shadow.sep_on);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_d;
      r_dp  <= w_dp_d;
      r_an  <= w_an_d;
    end
  end

  assign o_seg = r_seg;
  assign o_dp  = r_dp;
  assign o_an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_W = 4) against a cycle-count based display model.
module tb_seg7_scan_driver;

  localparam int unsigned SCAN_W = 4;
  localparam int SLOT  = 16;
  localparam int FRAME = 6 * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens, brightness;
  logic       blank_lead_zero, sep_on;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_n counts clock edges since reset; the displayed state follows from it directly.
  int         m_n;
  int         m_sh [6];
  bit         m_blz, m_sep;
  int         m_bri;
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  seg7_scan_driver #(.SCAN_W(SCAN_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_sec_ones        (sec_ones),
    .i_sec_tens        (sec_tens),
    .i_min_ones        (min_ones),
    .i_min_tens        (min_tens),
    .i_hour_ones       (hour_ones),
    .i_hour_tens       (hour_tens),
    .i_blank_lead_zero (blank_lead_zero),
    .i_sep_on          (sep_on),
    .i_brightness      (brightness),
    .o_seg             (seg),
    .o_dp              (dp),
    .o_an              (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(int v);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (v > 9) ? 7'h3F : tbl[v];
  endfunction

  task automatic model_reset();
    m_n = 0;
    foreach (m_sh[i]) m_sh[i] = 0;
    m_blz = 0; m_sep = 0; m_bri = 0;
    exp_an = 6'h3F; exp_seg = 7'h7F; exp_dp = 1'b1;
  endtask

  task automatic model_edge();
    int  ph  = m_n % SLOT;
    int  dig = (m_n / SLOT) % 6;
    bit  lead = (dig == 5) && m_blz && (m_sh[5] == 0);
    exp_an = 6'h3F;
    if (ph >= 1 && ph <= m_bri) exp_an[dig] = 1'b0;
    exp_seg = lead ? 7'h7F : ref_glyph(m_sh[dig]);
    exp_dp  = (!lead && (dig == 2 || dig == 4) && m_sep) ? 1'b0 : 1'b1;
    if (m_n % FRAME == FRAME - 1) begin
      m_sh[0] = sec_ones;  m_sh[1] = sec_tens;  m_sh[2] = min_ones;
      m_sh[3] = min_tens;  m_sh[4] = hour_ones; m_sh[5] = hour_tens;
      m_blz = blank_lead_zero; m_sep = sep_on; m_bri = brightness;
    end
    m_n++;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic int out_dig();
    return ((m_n - 1) / SLOT) % 6;
  endfunction

  function automatic int out_phase();
    return (m_n - 1) % SLOT;
  endfunction

  task automatic set_digits(int ht, int ho, int mt, int mo, int st, int so);
    hour_tens = 4'(ht); hour_ones = 4'(ho); min_tens = 4'(mt);
    min_ones  = 4'(mo); sec_tens  = 4'(st); sec_ones = 4'(so);
  endtask

  // Move to a frame boundary so the next advance shows slot 0 of a freshly captured frame.
  task automatic sync_frame();
    for (int i = 0; i < FRAME && (m_n % FRAME) != 0; i++) advance();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_digits(0, 0, 0, 0, 0, 0);
    brightness = 4'd0; blank_lead_zero = 1'b0; sep_on = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    n_checks++; if (an !== 6'h3F) begin n_fail++; $display("FAIL reset_an: got %h want 3f", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
    reset = 1'b0;
    set_digits(1, 2, 3, 4, 5, 6);
    brightness = 4'd15;
    for (int i = 0; i < FRAME; i++) begin
      advance();
      n_checks++;
      if (an !== 6'h3F || seg !== exp_seg || dp !== exp_dp) begin
        n_fail++;
        $display("FAIL dark_first_frame n=%0d: an=%h seg=%h dp=%b want an=3f seg=%h dp=%b",
                 m_n, an, seg, dp, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [5:0] seq [$];
    logic [5:0] want [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    int         low_cnt [6] = '{default: 0};
    logic [6:0] first_seg = 7'h7F;
    bit         got_first = 0;
    for (int i = 0; i < FRAME; i++) begin
      advance();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        n_fail++;
        $display("FAIL scan_model n=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (out_phase() == 0) begin
        n_checks++;
        if (an !== 6'h3F) begin n_fail++; $display("FAIL scan_ghost n=%0d: an=%h want 3f", m_n, an); end
      end
      if (an != 6'h3F) begin
        if (seq.size() == 0 || seq[$] != an) seq.push_back(an);
        for (int d = 0; d < 6; d++) if (!an[d]) low_cnt[d]++;
        if (!got_first) begin first_seg = seg; got_first = 1; end
      end
    end
    n_checks++;
    if (seq.size() != 6) begin n_fail++; $display("FAIL scan_len: got %0d want 6", seq.size()); end
    for (int i = 0; i < 6 && i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] !== want[i]) begin n_fail++; $display("FAIL scan_an[%0d]: got %h want %h", i, seq[i], want[i]); end
    end
    for (int d = 0; d < 6; d++) begin
      n_checks++;
      if (low_cnt[d] != 15) begin n_fail++; $display("FAIL scan_duty[%0d]: got %0d want 15", d, low_cnt[d]); end
    end
    n_checks++;
    if (first_seg !== 7'h02) begin n_fail++; $display("FAIL scan_first_seg: got %h want 02", first_seg); end
  endtask

  task automatic test_brightness();
    int lows = 0;
    brightness = 4'd3;
    advance(); sync_frame();
    for (int i = 0; i < FRAME; i++) begin
      advance();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        n_fail++;
        $display("FAIL bright3_model n=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (an != 6'h3F) lows++;
      n_checks++;
      if ((an != 6'h3F) !== (out_phase() >= 1 && out_phase() <= 3)) begin
        n_fail++; $display("FAIL bright3_phase n=%0d: phase=%0d an=%h", m_n, out_phase(), an);
      end
    end
    n_checks++;
    if (lows != 18) begin n_fail++; $display("FAIL bright3_total: got %0d want 18", lows); end
    brightness = 4'd0;
    advance(); sync_frame();
    for (int i = 0; i < FRAME; i++) begin
      advance();
      n_checks++;
      if (an !== 6'h3F) begin n_fail++; $display("FAIL bright0 n=%0d: an=%h want 3f", m_n, an); end
    end
  endtask

  task automatic test_lead_invalid();
    brightness = 4'd15;
    set_digits(0, 7, 3, 4'hC, 5, 9);
    blank_lead_zero = 1'b1;
    advance(); sync_frame();
    for (int i = 0; i < FRAME; i++) begin
      advance();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        n_fail++;
        $display("FAIL lead_model n=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (out_dig() == 5) begin
        n_checks++;
        if (seg !== 7'h7F || dp !== 1'b1) begin
          n_fail++; $display("FAIL lead_blank: seg=%h dp=%b want 7f 1", seg, dp);
        end
      end
      if (out_dig() == 2) begin
        n_checks++;
        if (seg !== 7'h3F) begin n_fail++; $display("FAIL invalid_dash: got %h want 3f", seg); end
      end
    end
    blank_lead_zero = 1'b0;
    advance(); sync_frame();
    for (int i = 0; i < FRAME; i++) begin
      advance();
      if (out_dig() == 5) begin
        n_checks++;
        if (seg !== 7'h40) begin n_fail++; $display("FAIL lead_zero_shown: got %h want 40", seg); end
      end
    end
  endtask

  task automatic test_separators();
    sep_on = 1'b1;
    advance(); sync_frame();
    for (int i = 0; i < FRAME; i++) begin
      advance();
      if (i == 40) sep_on = 1'b0;
      n_checks++;
      if (dp !== ((out_dig() == 2 || out_dig() == 4) ? 1'b0 : 1'b1) || dp !== exp_dp) begin
        n_fail++; $display("FAIL sep_on n=%0d dig=%0d: dp=%b want %b", m_n, out_dig(), dp, exp_dp);
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      advance();
      n_checks++;
      if (dp !== 1'b1) begin n_fail++; $display("FAIL sep_off n=%0d: dp=%b want 1", m_n, dp); end
    end
  endtask

  task automatic test_tearing();
    bit changed = 0;
    set_digits(1, 2, 3, 4, 5, 6);
    advance(); sync_frame();
    for (int i = 0; i < FRAME; i++) begin
      advance();
      if (out_dig() == 3 && !changed) begin set_digits(0, 4'hE, 0, 7, 8, 3); changed = 1; end
      n_checks++;
      if (seg !== exp_seg || an !== exp_an) begin
        n_fail++; $display("FAIL tear_model n=%0d: seg=%h an=%h want %h %h", m_n, seg, an, exp_seg, exp_an);
      end
      if (out_dig() >= 4) begin
        n_checks++;
        if (seg !== ((out_dig() == 4) ? 7'h24 : 7'h79)) begin
          n_fail++; $display("FAIL tear_old dig=%0d: got %h", out_dig(), seg);
        end
      end
    end
    advance();
    n_checks++;
    if (seg !== 7'h30) begin n_fail++; $display("FAIL tear_new: got %h want 30", seg); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FRAME; i++) begin
      advance();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        n_fail++;
        $display("FAIL random_model n=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if ($urandom_range(0, 19) == 0) begin
        set_digits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) hour_tens = 4'd0;
        blank_lead_zero = 1'($urandom_range(0, 1));
        sep_on          = 1'($urandom_range(0, 1));
        brightness      = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic test_reset_mid();
    brightness = 4'd15;
    set_digits(2, 3, 5, 9, 5, 8);
    advance(); sync_frame();
    repeat (37) advance();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (an !== 6'h3F) begin n_fail++; $display("FAIL midreset_an: got %h want 3f", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL midreset_seg: got %h want 7f", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL midreset_dp: got %b want 1", dp); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < FRAME + SLOT; i++) begin
      advance();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || (i < FRAME && an !== 6'h3F)) begin
        n_fail++;
        $display("FAIL midreset_after n=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_brightness();
    test_lead_invalid();
    test_separators();
    test_tearing();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
